// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, PC+step adder and IF/ID pipeline register,
// with a saturating count of cycles in which the PC was held.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             PCWrite,
    input  logic             IFIDWrite,
    input  logic             PCSrc,
    input  logic [31:0]      BranchTarget,
    input  logic             Flush,
    input  logic [31:0]      InstrIn,
    output logic [31:0]      PCOut,
    output logic [31:0]      IFID_Instruction,
    output logic [31:0]      IFID_PCPlus4,
    output logic             IFID_Valid,
    output logic [CNT_W-1:0] StallCount
);

    logic [31:0] pcPlus4;

    // Wraps modulo 2^32 by construction.
    assign pcPlus4 = PCOut + 32'(PC_STEP);

    // A pending redirect outranks a load-use hold: the branch is the older instruction.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            PCOut <= RESET_PC;
        end else if (PCSrc) begin
            PCOut <= BranchTarget;
        end else if (PCWrite) begin
            PCOut <= pcPlus4;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            IFID_Instruction <= '0;
            IFID_PCPlus4     <= '0;
            IFID_Valid       <= 1'b0;
        end else if (Flush) begin
            IFID_Instruction <= '0;
            IFID_PCPlus4     <= '0;
            IFID_Valid       <= 1'b0;
        end else if (IFIDWrite) begin
            IFID_Instruction <= InstrIn;
            IFID_PCPlus4     <= pcPlus4;
            IFID_Valid       <= 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            StallCount <= '0;
        end else if (!PCWrite && !PCSrc && (StallCount != '1)) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized and directed bench for if_stage against a cycle-level reference model;
// a second instance with a 4-bit counter exercises saturation.
module tb_if_stage;

    logic        Clk;
    logic        Reset;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic        Flush;
    logic [31:0] InstrIn;

    logic [31:0] PCOut, IFID_Instruction, IFID_PCPlus4;
    logic        IFID_Valid;
    logic [15:0] StallCount;

    logic [31:0] sPCOut, sIFID_Instruction, sIFID_PCPlus4;
    logic        sIFID_Valid;
    logic [3:0]  sStallCount;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // reference model state
    logic [31:0] mPc, mInstr, mPcPlus4;
    logic        mValid;
    int unsigned mCount;

    if_stage #(.RESET_PC(32'h00000000), .PC_STEP(4), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .PCSrc(PCSrc), .BranchTarget(BranchTarget), .Flush(Flush), .InstrIn(InstrIn),
        .PCOut(PCOut), .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
        .IFID_Valid(IFID_Valid), .StallCount(StallCount)
    );

    if_stage #(.CNT_W(4)) dutSmall (
        .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .PCSrc(PCSrc), .BranchTarget(BranchTarget), .Flush(Flush), .InstrIn(InstrIn),
        .PCOut(sPCOut), .IFID_Instruction(sIFID_Instruction), .IFID_PCPlus4(sIFID_PCPlus4),
        .IFID_Valid(sIFID_Valid), .StallCount(sStallCount)
    );

    function automatic logic [31:0] imemWord(input logic [31:0] a);
        case (a)
            32'h00000000: return 32'h20080005;
            32'h00000004: return 32'h20090003;
            default:      return {a[15:0], a[31:16]} ^ 32'h5A5AC3C3;
        endcase
    endfunction

    always_comb InstrIn = imemWord(PCOut);

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPc = 32'h0; mInstr = 32'h0; mPcPlus4 = 32'h0; mValid = 1'b0; mCount = 0;
    endtask

    task automatic checkAll(input string tag);
        checkEq({tag, ".pc"},    PCOut, mPc);
        checkEq({tag, ".instr"}, IFID_Instruction, mInstr);
        checkEq({tag, ".pcp4"},  IFID_PCPlus4, mPcPlus4);
        checkEq({tag, ".valid"}, 32'(IFID_Valid), 32'(mValid));
        checkEq({tag, ".cnt"},   32'(StallCount), (mCount > 65535) ? 32'd65535 : mCount);
        checkEq({tag, ".spc"},   sPCOut, mPc);
        checkEq({tag, ".sinstr"}, sIFID_Instruction, mInstr);
        checkEq({tag, ".spcp4"}, sIFID_PCPlus4, mPcPlus4);
        checkEq({tag, ".svalid"}, 32'(sIFID_Valid), 32'(mValid));
        checkEq({tag, ".scnt"},  32'(sStallCount), (mCount > 15) ? 32'd15 : mCount);
    endtask

    // Advance the model by one clock using the inputs currently applied, then compare.
    task automatic step(input string tag);
        logic [31:0] fetchPc;
        fetchPc = mPc;
        if (Flush) begin
            mInstr = 32'h0; mPcPlus4 = 32'h0; mValid = 1'b0;
        end else if (IFIDWrite) begin
            mInstr = imemWord(fetchPc); mPcPlus4 = fetchPc + 32'd4; mValid = 1'b1;
        end
        if (PCSrc)        mPc = BranchTarget;
        else if (PCWrite) mPc = fetchPc + 32'd4;
        else              mCount++;
        @(posedge Clk);
        #1;
        checkAll(tag);
    endtask

    task automatic drive(input logic pw, input logic iw, input logic src,
                         input logic [31:0] bt, input logic fl);
        PCWrite = pw; IFIDWrite = iw; PCSrc = src; BranchTarget = bt; Flush = fl;
    endtask

    initial begin
        Reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        modelReset();
        repeat (2) @(posedge Clk);
        #1;
        checkAll("reset");
        @(negedge Clk);
        Reset = 1'b0;

        // three fetches, then asynchronous reset between edges
        repeat (3) step("fetch");
        #3;
        Reset = 1'b1;
        #1;
        modelReset();
        checkAll("asyncReset");
        @(negedge Clk);
        Reset = 1'b0;

        // sequential fetch 0,4,8
        step("seq0");
        checkEq("seq0.instrConst", IFID_Instruction, 32'h20080005);
        checkEq("seq0.pcp4Const", IFID_PCPlus4, 32'h4);
        step("seq1");
        checkEq("seq1.pcConst", PCOut, 32'h8);

        // one load-use stall at PC 8
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("stall");
        checkEq("stall.pcConst", PCOut, 32'h8);
        checkEq("stall.cntConst", 32'(StallCount), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step("resume");
        checkEq("resume.pcConst", PCOut, 32'hC);
        step("toSixteen");

        // taken branch at PC 16
        drive(1'b1, 1'b1, 1'b1, 32'h00000040, 1'b1);
        step("branch");
        checkEq("branch.pcConst", PCOut, 32'h40);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step("target");
        checkEq("target.pcp4Const", IFID_PCPlus4, 32'h44);

        // redirect beats stall, flush beats hold
        drive(1'b0, 1'b0, 1'b1, 32'h00001230, 1'b1);
        step("simul");

        // PC wrap-around
        drive(1'b1, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b1);
        step("toTop");
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step("wrap");
        checkEq("wrap.pcConst", PCOut, 32'h0);
        checkEq("wrap.pcp4Const", IFID_PCPlus4, 32'h0);

        // 20 stalls saturate the 4-bit counter
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) step("satur");
        checkEq("satur.smallConst", 32'(sStallCount), 32'hF);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0), $urandom() & 32'hFFFFFFFC,
                  ($urandom_range(0, 7) == 0));
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
